// File: rtl/event_frame_reader_if.sv
// Bundles the FIFO read-side signals, the framed output stream and the status
// counters of event_frame_reader.
interface event_frame_reader_if;
  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_valid;
  logic        fifo_rd_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] evt_count;
  logic [7:0]  err_count;
  logic        busy;

  modport master (
    output fifo_dout, fifo_empty, fifo_valid, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last, evt_count, err_count, busy
  );
  modport slave (
    input  fifo_dout, fifo_empty, fifo_valid, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last, evt_count, err_count, busy
  );
endinterface

// File: rtl/event_frame_reader.sv
// Pops tagged tube words from the event FIFO, checks the 32-word tag sequence of
// each event and emits a header + hit-word frame on a valid/ready stream.
module event_frame_reader #(
  parameter logic [7:0] HDR_TAG    = 8'hE5,
  parameter logic [7:0] HIT_THRESH = 8'd1,
  parameter bit         SKIP_EMPTY = 1'b1
) (
  input logic clk100,
  input logic rst,
  event_frame_reader_if.slave bus
);
  localparam logic [1:0] HUNT = 2'd0, COLLECT = 2'd1, HDR = 2'd2, EMIT = 2'd3;
  localparam logic [7:0] TAG_FIRST = 8'hC0, TAG_FILL = 8'h00;

  logic [1:0]  state;
  logic [4:0]  k, rd_ptr;
  logic [5:0]  hit_cnt, hit_final;
  logic        skid_full;
  logic [15:0] skid_word;
  logic [15:0] evt_count;
  logic [7:0]  err_count;
  logic [12:0] hit_buf [32];

  logic        in_valid, in_hit, in_exp, in_first, in_fill;
  logic [15:0] in_word;
  logic        collecting, accept, restart, mismatch, stray;
  logic        out_valid, out_last, handshake;
  logic [15:0] out_data;

  function automatic logic [7:0] exp_tag(input logic [4:0] idx);
    return {(idx[4] ? 4'h2 : 4'hC), idx[3], idx[0], idx[1], idx[2]};
  endfunction

  // A word popped while framing is parked in the skid and takes priority later.
  assign in_valid   = skid_full | bus.fifo_valid;
  assign in_word    = skid_full ? skid_word : bus.fifo_dout;
  assign in_hit     = in_word[7:0] >= HIT_THRESH;
  assign in_exp     = in_word[15:8] == exp_tag(k);
  assign in_first   = in_word[15:8] == TAG_FIRST;
  assign in_fill    = in_word[15:8] == TAG_FILL;
  assign hit_final  = hit_cnt + {5'd0, in_hit};
  assign collecting = (state == HUNT) || (state == COLLECT);

  assign accept   = (state == COLLECT) && in_valid && in_exp;
  assign mismatch = (state == COLLECT) && in_valid && !in_exp;
  assign stray    = (state == HUNT) && in_valid && !in_first && !in_fill;
  assign restart  = collecting && in_valid && in_first && !accept;

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 16'h0000;
    if (state == HDR) begin
      out_valid = 1'b1;
      out_last  = (hit_cnt == 6'd0);
      out_data  = {HDR_TAG, 2'b00, hit_cnt};
    end else if (state == EMIT) begin
      out_valid = 1'b1;
      out_last  = ({1'b0, rd_ptr} == hit_cnt - 6'd1);
      out_data  = {3'b000, hit_buf[rd_ptr]};
    end
  end
  assign handshake = out_valid && bus.out_ready;

  // Hit storage needs no reset: only entries below hit_cnt are ever read.
  always_ff @(posedge clk100) begin
    if ((accept || restart) && in_hit)
      hit_buf[accept ? hit_cnt[4:0] : 5'd0] <= {(accept ? k : 5'd0), in_word[7:0]};
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      k         <= 5'd0;
      rd_ptr    <= 5'd0;
      hit_cnt   <= 6'd0;
      skid_full <= 1'b0;
      skid_word <= 16'h0000;
      evt_count <= 16'h0000;
      err_count <= 8'h00;
    end else begin
      if (!collecting && bus.fifo_valid) begin
        skid_full <= 1'b1;
        skid_word <= bus.fifo_dout;
      end else if (collecting) begin
        skid_full <= 1'b0;
      end

      if ((mismatch || stray) && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (accept && k == 5'd31 && evt_count != 16'hFFFF) evt_count <= evt_count + 16'd1;

      case (state)
        HUNT, COLLECT: begin
          if (restart) begin
            k       <= 5'd1;
            hit_cnt <= {5'd0, in_hit};
            state   <= COLLECT;
          end else if (accept) begin
            hit_cnt <= hit_final;
            if (k == 5'd31) state <= (SKIP_EMPTY && hit_final == 6'd0) ? HUNT : HDR;
            else            k     <= k + 5'd1;
          end else if (mismatch) begin
            state <= HUNT;
          end
        end
        HDR: if (handshake) begin
          rd_ptr <= 5'd0;
          state  <= out_last ? HUNT : EMIT;
        end
        default: if (handshake) begin
          rd_ptr <= rd_ptr + 5'd1;
          if (out_last) state <= HUNT;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = !bus.fifo_empty && !skid_full && collecting;
  assign bus.out_valid  = out_valid;
  assign bus.out_last   = out_last;
  assign bus.out_data   = out_data;
  assign bus.evt_count  = evt_count;
  assign bus.err_count  = err_count;
  assign bus.busy       = (state != HUNT);
endmodule
